// File: rtl/if_loader_ctrl_if.sv
// Bus between the debug UART receive path / fetch stage and the loader controller.
//   master : environment side (drives received bytes and the fetched word)
//   slave  : if_loader_ctrl (drives fetch control, memory write port and status)
// Signals:
//   i_rx_data/i_rx_valid  received byte and its one-cycle strobe
//   i_instruction         word currently output by fetch
//   o_pc_enable/o_pc_reset, o_read_enable, o_instru_mem_enable  fetch control
//   o_write_enable/o_write_data/o_write_addr                    byte write port
//   o_loaded, o_done, o_cycle_count, o_state                    status / debug
interface if_loader_ctrl_if #(
  parameter int unsigned INSTRUCTION_SIZE = 32,
  parameter int unsigned INSTMEM_SIZE     = 8,
  parameter int unsigned MEM_SIZE         = 8
);
  logic [7:0]                  i_rx_data;
  logic                        i_rx_valid;
  logic [INSTRUCTION_SIZE-1:0] i_instruction;
  logic                        o_pc_enable;
  logic                        o_pc_reset;
  logic                        o_read_enable;
  logic                        o_instru_mem_enable;
  logic                        o_write_enable;
  logic [MEM_SIZE-1:0]         o_write_data;
  logic [INSTMEM_SIZE-1:0]     o_write_addr;
  logic                        o_loaded;
  logic                        o_done;
  logic [31:0]                 o_cycle_count;
  logic [2:0]                  o_state;

  modport master (
    output i_rx_data, i_rx_valid, i_instruction,
    input  o_pc_enable, o_pc_reset, o_read_enable, o_instru_mem_enable, o_write_enable,
    input  o_write_data, o_write_addr, o_loaded, o_done, o_cycle_count, o_state
  );

  modport slave (
    input  i_rx_data, i_rx_valid, i_instruction,
    output o_pc_enable, o_pc_reset, o_read_enable, o_instru_mem_enable, o_write_enable,
    output o_write_data, o_write_addr, o_loaded, o_done, o_cycle_count, o_state
  );
endinterface

// File: rtl/if_loader_ctrl.sv
// Instruction-fetch sequencer. Loads a program byte-by-byte from UART commands into
// instruction memory, then drives PC reset / PC enable / read enables in continuous
// or single-step mode until the HALT word is fetched.
// Ports:
//   i_clock  system clock, rising edge
//   i_reset  asynchronous, active-low reset
//   bus      if_loader_ctrl_if.slave (rx byte in, fetched word in, control/status out)
// Every output is a register; a byte sampled at an edge is acted on at that edge and
// shows on the outputs in the following cycle.
module if_loader_ctrl #(
  parameter int unsigned                  PC_SIZE          = 32,
  parameter int unsigned                  INSTRUCTION_SIZE = 32,
  parameter int unsigned                  INSTMEM_SIZE     = 8,
  parameter int unsigned                  MEM_SIZE         = 8,
  parameter logic [INSTRUCTION_SIZE-1:0]  HALT_WORD        = 32'hFFFFFFFF,
  parameter logic [7:0]                   CMD_LOAD         = 8'h4C,
  parameter logic [7:0]                   CMD_RUN          = 8'h43,
  parameter logic [7:0]                   CMD_STEP         = 8'h53,
  parameter logic [7:0]                   CMD_NEXT         = 8'h4E
) (
  input  logic     i_clock,
  input  logic     i_reset,
  if_loader_ctrl_if.slave bus
);

  // One extra bit so a full memory (4*64 = 256 bytes) is representable as a total.
  localparam int unsigned CntW     = INSTMEM_SIZE + 1;
  localparam int unsigned MaxWords = (1 << INSTMEM_SIZE) / 4;

  if (PC_SIZE == 0 || INSTMEM_SIZE < 2 || MEM_SIZE == 0) begin : g_bad_params
    $error("if_loader_ctrl: unsupported parameter set");
  end

  typedef enum logic [2:0] {
    StIdle,
    StLoadLen,
    StLoadData,
    StRunRst,
    StRun,
    StStepWait,
    StStepExec,
    StHalted
  } state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         byte_cnt_q, byte_cnt_d;
  logic [CntW-1:0]         total_q, total_d;
  logic                    step_mode_q, step_mode_d;
  logic                    loaded_q, loaded_d;
  logic                    done_q, done_d;
  logic                    wr_en_q, wr_en_d;
  logic [MEM_SIZE-1:0]     wr_data_q, wr_data_d;
  logic [INSTMEM_SIZE-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]             cycle_q, cycle_d;
  logic                    pc_en_q, pc_en_d;
  logic                    pc_rst_q, pc_rst_d;
  logic                    rd_en_q, rd_en_d;
  logic                    mem_en_q, mem_en_d;

  logic [7:0] rx;
  logic       rx_valid;
  logic       halt_hit;

  assign rx       = bus.i_rx_data;
  assign rx_valid = bus.i_rx_valid;

  // HALT only counts while the word was actually being fetched with the PC advancing.
  assign halt_hit = pc_en_q && (bus.i_instruction == HALT_WORD) &&
                    ((state_q == StRun) || (state_q == StStepExec));

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    total_d     = total_q;
    step_mode_d = step_mode_q;
    loaded_d    = loaded_q;
    done_d      = done_q;
    wr_en_d     = 1'b0;
    wr_data_d   = wr_data_q;
    wr_addr_d   = wr_addr_q;
    cycle_d     = pc_en_q ? cycle_q + 32'd1 : cycle_q;

    unique case (state_q)
      StIdle, StHalted: begin
        if (rx_valid) begin
          if (rx == CMD_LOAD) begin
            state_d  = StLoadLen;
            loaded_d = 1'b0;
            done_d   = 1'b0;
          end else if (loaded_q && (rx == CMD_RUN || rx == CMD_STEP)) begin
            state_d     = StRunRst;
            step_mode_d = (rx == CMD_STEP);
            done_d      = 1'b0;
            cycle_d     = '0;
          end
        end
      end

      StLoadLen: begin
        if (rx_valid) begin
          if (rx == 8'h00) begin
            state_d = StIdle;
          end else begin
            if (32'(rx) > MaxWords) begin
              total_d = CntW'(MaxWords * 32'd4);
            end else begin
              total_d = CntW'(32'(rx) * 32'd4);
            end
            byte_cnt_d = '0;
            state_d    = StLoadData;
          end
        end
      end

      StLoadData: begin
        // The cycle after the last write pulse closes the load.
        if (byte_cnt_q == total_q) begin
          state_d  = StIdle;
          loaded_d = 1'b1;
        end else if (rx_valid) begin
          wr_en_d    = 1'b1;
          wr_data_d  = MEM_SIZE'(rx);
          wr_addr_d  = byte_cnt_q[INSTMEM_SIZE-1:0];
          byte_cnt_d = byte_cnt_q + 1'b1;
        end
      end

      StRunRst: begin
        state_d = step_mode_q ? StStepWait : StRun;
      end

      StRun: begin
        if (halt_hit) begin
          state_d = StHalted;
          done_d  = 1'b1;
        end
      end

      StStepWait: begin
        if (rx_valid) begin
          if (rx == CMD_NEXT) begin
            state_d = StStepExec;
          end else if (rx == CMD_RUN) begin
            state_d = StRun;
          end
        end
      end

      StStepExec: begin
        if (halt_hit) begin
          state_d = StHalted;
          done_d  = 1'b1;
        end else begin
          state_d = StStepWait;
        end
      end

      default: state_d = StIdle;
    endcase

    // Control strobes are decoded from the next state so they line up with it.
    pc_en_d  = (state_d == StRun) || (state_d == StStepExec);
    pc_rst_d = (state_d == StRunRst);
    rd_en_d  = (state_d == StRun) || (state_d == StStepWait) || (state_d == StStepExec);
    mem_en_d = rd_en_d || (state_d == StLoadData);
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= StIdle;
      byte_cnt_q  <= '0;
      total_q     <= '0;
      step_mode_q <= 1'b0;
      loaded_q    <= 1'b0;
      done_q      <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_data_q   <= '0;
      wr_addr_q   <= '0;
      cycle_q     <= '0;
      pc_en_q     <= 1'b0;
      pc_rst_q    <= 1'b0;
      rd_en_q     <= 1'b0;
      mem_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      total_q     <= total_d;
      step_mode_q <= step_mode_d;
      loaded_q    <= loaded_d;
      done_q      <= done_d;
      wr_en_q     <= wr_en_d;
      wr_data_q   <= wr_data_d;
      wr_addr_q   <= wr_addr_d;
      cycle_q     <= cycle_d;
      pc_en_q     <= pc_en_d;
      pc_rst_q    <= pc_rst_d;
      rd_en_q     <= rd_en_d;
      mem_en_q    <= mem_en_d;
    end
  end

  assign bus.o_pc_enable         = pc_en_q;
  assign bus.o_pc_reset          = pc_rst_q;
  assign bus.o_read_enable       = rd_en_q;
  assign bus.o_instru_mem_enable = mem_en_q;
  assign bus.o_write_enable      = wr_en_q;
  assign bus.o_write_data        = wr_data_q;
  assign bus.o_write_addr        = wr_addr_q;
  assign bus.o_loaded            = loaded_q;
  assign bus.o_done              = done_q;
  assign bus.o_cycle_count       = cycle_q;
  assign bus.o_state             = state_q;

endmodule

// File: tb/tb_if_loader_ctrl.sv
module tb_if_loader_ctrl;
  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_RUN  = 8'h43;
  localparam logic [7:0] CMD_STEP = 8'h53;
  localparam logic [7:0] CMD_NEXT = 8'h4E;
  localparam logic [2:0] S_IDLE = 3'd0, S_LOAD_DATA = 3'd2, S_RUN = 3'd4;
  localparam logic [2:0] S_STEP_WAIT = 3'd5, S_HALTED = 3'd7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  if_loader_ctrl_if bus ();
  if_loader_ctrl dut (.i_clock(clk), .i_reset(rst_n), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference program image and expectation queues.
  logic [7:0]  mem_model [256];
  logic [15:0] exp_wr_q [$];    // {addr, data} per expected write pulse
  int          exp_rst_q [$];   // one token per expected PC reset pulse
  logic [31:0] exp_halt_q [$];  // expected cycle count at each halt
  int          pc = 0;
  int          pc_en_pulses = 0;
  logic        rst_prev = 1'b0;
  logic        done_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input logic [31:0] act);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got %0h, expected no such event", name, act);
  endtask

  function automatic logic [31:0] word_at(input int p);
    int b;
    b = (4 * p) % 256;
    return {mem_model[(b + 3) % 256], mem_model[(b + 2) % 256], mem_model[b + 1],
            mem_model[b]};
  endfunction

  // Fetch-stage stand-in: word-indexed PC over the program image.
  always @(posedge clk) begin
    if (bus.o_pc_reset) pc <= 0;
    else if (bus.o_pc_enable) pc <= pc + 1;
  end
  assign bus.i_instruction = word_at(pc);

  // Monitor: pops the scoreboard whenever the DUT presents an event.
  always @(posedge clk) begin
    logic [15:0] ew;
    logic [31:0] eh;
    #1;
    if (rst_n) begin
      if (bus.o_write_enable) begin
        if (exp_wr_q.size() == 0) begin
          flag("unexpected_write", {bus.o_write_addr, bus.o_write_data});
        end else begin
          ew = exp_wr_q.pop_front();
          check("write_addr", 32'(bus.o_write_addr), 32'(ew[15:8]));
          check("write_data", 32'(bus.o_write_data), 32'(ew[7:0]));
        end
      end
      if (bus.o_pc_reset) begin
        if (exp_rst_q.size() == 0) begin
          flag("unexpected_pc_reset", 32'(bus.o_state));
        end else begin
          void'(exp_rst_q.pop_front());
          check("pc_reset_count_clear", bus.o_cycle_count, 0);
          check("pc_reset_done_clear", 32'(bus.o_done), 0);
        end
        if (rst_prev) flag("pc_reset_width", 32'(bus.o_pc_reset));
      end
      rst_prev = bus.o_pc_reset;
      if (bus.o_pc_enable) pc_en_pulses++;
      if (bus.o_done && !done_prev) begin
        if (exp_halt_q.size() == 0) begin
          flag("unexpected_halt", bus.o_cycle_count);
        end else begin
          eh = exp_halt_q.pop_front();
          check("halt_cycle_count", bus.o_cycle_count, eh);
          check("halt_pc_enable", 32'(bus.o_pc_enable), 0);
          check("halt_state", 32'(bus.o_state), 32'(S_HALTED));
        end
      end
      done_prev = bus.o_done;
    end else begin
      rst_prev  = 1'b0;
      done_prev = 1'b0;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge after the byte was sampled.
  task automatic send(input logic [7:0] b);
    bus.i_rx_data  = b;
    bus.i_rx_valid = 1'b1;
    @(negedge clk);
    bus.i_rx_valid = 1'b0;
  endtask

  // Load a program of n words (clamped to 64); word halt_idx is the HALT word.
  task automatic load(input logic [7:0] n, input int halt_idx, input bit gaps);
    int words;
    logic [7:0] b;
    send(CMD_LOAD);
    send(n);
    words = (n > 8'd64) ? 64 : int'(n);
    if (words == 0) begin
      check("load0_state", 32'(bus.o_state), 32'(S_IDLE));
      check("load0_loaded", 32'(bus.o_loaded), 0);
      idle(2);
      check("load0_loaded_later", 32'(bus.o_loaded), 0);
      return;
    end
    for (int w = 0; w < words; w++) begin
      for (int k = 0; k < 4; k++) begin
        b = (w == halt_idx) ? 8'hFF : 8'($urandom);
        if (w != halt_idx && k == 0 && b == 8'hFF) b = 8'h00;
        mem_model[4 * w + k] = b;
        exp_wr_q.push_back({8'(4 * w + k), b});
        send(b);
        if (gaps && !(w == words - 1 && k == 3) && $urandom_range(0, 2) == 0)
          idle($urandom_range(1, 2));
      end
    end
    check("load_loaded_during_last_write", 32'(bus.o_loaded), 0);
    check("load_mem_enable", 32'(bus.o_instru_mem_enable), 1);
    idle(1);
    check("load_loaded", 32'(bus.o_loaded), 1);
    check("load_state_idle", 32'(bus.o_state), 32'(S_IDLE));
  endtask

  task automatic wait_done();
    int t = 0;
    while (!bus.o_done && t < 500) begin
      idle(1);
      t++;
    end
    if (!bus.o_done) flag("halt_timeout", 32'(bus.o_state));
    else check("halted_pc_enable", 32'(bus.o_pc_enable), 0);
  endtask

  task automatic run_to_halt(input logic [31:0] exp_count, input bit junk);
    exp_rst_q.push_back(1);
    exp_halt_q.push_back(exp_count);
    send(CMD_RUN);
    check("run_pc_reset", 32'(bus.o_pc_reset), 1);
    check("run_done_cleared", 32'(bus.o_done), 0);
    idle(1);
    check("run_pc_enable", 32'(bus.o_pc_enable), 1);
    check("run_read_enable", 32'(bus.o_read_enable), 1);
    check("run_state", 32'(bus.o_state), 32'(S_RUN));
    if (junk) send(CMD_LOAD);
    wait_done();
  endtask

  initial begin
    int n, h, base;
    bus.i_rx_data  = 8'h00;
    bus.i_rx_valid = 1'b0;
    for (int i = 0; i < 256; i++) mem_model[i] = 8'h00;

    #1;
    check("reset_state", 32'(bus.o_state), 32'(S_IDLE));
    check("reset_outputs", {bus.o_pc_enable, bus.o_pc_reset, bus.o_read_enable,
          bus.o_instru_mem_enable, bus.o_write_enable, bus.o_loaded, bus.o_done}, 0);
    check("reset_cycle_count", bus.o_cycle_count, 0);
    idle(2);
    rst_n = 1'b1;
    idle(1);

    // Guards: RUN/STEP before any load and junk bytes are ignored.
    send(CMD_RUN);
    send(CMD_STEP);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] j;
      j = 8'($urandom);
      if (j == CMD_LOAD || j == CMD_RUN || j == CMD_STEP) j = 8'h00;
      send(j);
    end
    idle(1);
    check("guard_state", 32'(bus.o_state), 32'(S_IDLE));

    // Two-word program, HALT at word 1, then restart from HALTED.
    load(8'd2, 1, 1'b0);
    run_to_halt(32'd2, 1'b0);
    check("halted_loaded", 32'(bus.o_loaded), 1);
    run_to_halt(32'd2, 1'b0);

    // Zero-length load leaves nothing resident; RUN is then ignored.
    load(8'd0, -1, 1'b0);
    send(CMD_RUN);
    idle(1);
    check("run_after_empty_load", 32'(bus.o_state), 32'(S_IDLE));

    // Random programs with gaps between bytes and ignored bytes during RUN.
    for (int it = 0; it < 3; it++) begin
      n = $urandom_range(5, 8);
      h = $urandom_range(4, n - 1);
      load(8'(n), h, 1'b1);
      run_to_halt(32'(h + 1), 1'b1);
    end

    // Single-step: three NEXT pulses, then RUN continues without a PC reset.
    load(8'd6, 5, 1'b0);
    base = pc_en_pulses;
    exp_rst_q.push_back(1);
    send(CMD_STEP);
    check("step_pc_reset", 32'(bus.o_pc_reset), 1);
    idle(1);
    check("step_wait_pc_enable", 32'(bus.o_pc_enable), 0);
    check("step_wait_read_enable", 32'(bus.o_read_enable), 1);
    send(CMD_LOAD);
    send(CMD_STEP);
    check("step_wait_ignores", 32'(bus.o_state), 32'(S_STEP_WAIT));
    for (int i = 0; i < 3; i++) begin
      idle($urandom_range(0, 2));
      send(CMD_NEXT);
      check("step_pulse_high", 32'(bus.o_pc_enable), 1);
      idle(1);
      check("step_pulse_low", 32'(bus.o_pc_enable), 0);
      check("step_back_to_wait", 32'(bus.o_state), 32'(S_STEP_WAIT));
    end
    check("step_pulse_count", 32'(pc_en_pulses - base), 3);
    check("step_cycle_count", bus.o_cycle_count, 3);
    exp_halt_q.push_back(32'd6);
    send(CMD_RUN);
    check("step_to_run_no_reset", 32'(bus.o_pc_reset), 0);
    check("step_to_run_state", 32'(bus.o_state), 32'(S_RUN));
    wait_done();

    // HALT fetched during a step wins over the return to STEP_WAIT.
    load(8'd2, 1, 1'b0);
    exp_rst_q.push_back(1);
    exp_halt_q.push_back(32'd2);
    send(CMD_STEP);
    idle(1);
    send(CMD_NEXT);
    idle(1);
    send(CMD_NEXT);
    idle(1);
    check("step_halt_state", 32'(bus.o_state), 32'(S_HALTED));
    check("step_halt_done", 32'(bus.o_done), 1);

    // Oversized length clamps to 64 words: 256 writes, addresses 0..255.
    load(8'hFF, -1, 1'b0);

    // Asynchronous reset in the middle of a load.
    send(CMD_LOAD);
    send(8'd4);
    for (int i = 0; i < 5; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      exp_wr_q.push_back({8'(i), b});
      send(b);
    end
    check("midload_state", 32'(bus.o_state), 32'(S_LOAD_DATA));
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {bus.o_pc_enable, bus.o_pc_reset, bus.o_read_enable,
          bus.o_instru_mem_enable, bus.o_write_enable, bus.o_loaded, bus.o_done}, 0);
    check("async_reset_state", 32'(bus.o_state), 32'(S_IDLE));
    check("async_reset_addr", 32'(bus.o_write_addr), 0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    send(CMD_RUN);
    idle(1);
    check("run_after_abort", 32'(bus.o_state), 32'(S_IDLE));

    // Reload from address 0 and halt on the very first word.
    load(8'd2, 0, 1'b1);
    run_to_halt(32'd1, 1'b0);

    idle(3);
    check("write_queue_drained", 32'(exp_wr_q.size()), 0);
    check("reset_queue_drained", 32'(exp_rst_q.size()), 0);
    check("halt_queue_drained", 32'(exp_halt_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
